// File: rtl/cpu_pkg.sv
// Shared types for the five-stage pipeline control path:
// forwarding selects, hazard FSM states and the shadow slot.
package cpu_pkg;

  localparam int SLOT_RW = 5;

  localparam logic [SLOT_RW-1:0] REG_ZERO = '0;

  localparam logic [1:0] FWD_IDEX = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WR   = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic               valid;
    logic               reg_wr;
    logic [SLOT_RW-1:0] rw;
    logic               mem_to_reg;
    logic [SLOT_RW-1:0] rs;
    logic [SLOT_RW-1:0] rt;
  } slot_t;

endpackage

// File: rtl/hazard_ctrl_dep_match.sv
// dep_match: does one in-flight slot write register r?
// Register zero never matches.
module dep_match
  import cpu_pkg::*;
(
  input  logic               valid,
  input  logic               reg_wr,
  input  logic [SLOT_RW-1:0] rw,
  input  logic [SLOT_RW-1:0] r,
  output logic               hit
);

  assign hit = valid & reg_wr & (rw == r) & (r != REG_ZERO);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall, bubble, flush and EX forwarding.
// FORWARD_EN enables bypassing; otherwise stalls until WR drains.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_reg_wr,
  input  logic [REG_W-1:0] id_rw,
  input  logic             id_mem_to_reg,
  input  logic             ex_br_taken,
  output logic             pc_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       fsm_state
);

  slot_t ex_q, mem_q, wr_q, ex_d;
  hz_state_t state_q, state_d;

  logic [SLOT_RW-1:0] rs_n, rt_n;
  logic ex_rs, ex_rt;
  logic hazard;

  assign rs_n = SLOT_RW'(id_rs);
  assign rt_n = SLOT_RW'(id_rt);

  dep_match u_ex_rs (
    .valid (ex_q.valid),
    .reg_wr(ex_q.reg_wr),
    .rw    (ex_q.rw),
    .r     (rs_n),
    .hit   (ex_rs)
  );

  dep_match u_ex_rt (
    .valid (ex_q.valid),
    .reg_wr(ex_q.reg_wr),
    .rw    (ex_q.rw),
    .r     (rt_n),
    .hit   (ex_rt)
  );

`ifdef FORWARD_EN
  logic mem_a, mem_b, wr_a, wr_b;

  dep_match u_mem_a (
    .valid (mem_q.valid),
    .reg_wr(mem_q.reg_wr),
    .rw    (mem_q.rw),
    .r     (ex_q.rs),
    .hit   (mem_a)
  );

  dep_match u_mem_b (
    .valid (mem_q.valid),
    .reg_wr(mem_q.reg_wr),
    .rw    (mem_q.rw),
    .r     (ex_q.rt),
    .hit   (mem_b)
  );

  dep_match u_wr_a (
    .valid (wr_q.valid),
    .reg_wr(wr_q.reg_wr),
    .rw    (wr_q.rw),
    .r     (ex_q.rs),
    .hit   (wr_a)
  );

  dep_match u_wr_b (
    .valid (wr_q.valid),
    .reg_wr(wr_q.reg_wr),
    .rw    (wr_q.rw),
    .r     (ex_q.rt),
    .hit   (wr_b)
  );

  // Only a load in EX cannot be bypassed in time.
  assign hazard = id_valid & ex_q.mem_to_reg &
                  ((id_use_rs & ex_rs) | (id_use_rt & ex_rt));

  // A load sitting in MEM has no ALU result to forward.
  always_comb begin
    fwd_a = FWD_IDEX;
    if (mem_a && !mem_q.mem_to_reg) fwd_a = FWD_MEM;
    else if (wr_a)                  fwd_a = FWD_WR;
  end

  always_comb begin
    fwd_b = FWD_IDEX;
    if (mem_b && !mem_q.mem_to_reg) fwd_b = FWD_MEM;
    else if (wr_b)                  fwd_b = FWD_WR;
  end

  logic unused_mode;
  assign unused_mode = wr_q.mem_to_reg;
`else
  logic mem_rs, mem_rt, wr_rs, wr_rt;

  dep_match u_mem_rs (
    .valid (mem_q.valid),
    .reg_wr(mem_q.reg_wr),
    .rw    (mem_q.rw),
    .r     (rs_n),
    .hit   (mem_rs)
  );

  dep_match u_mem_rt (
    .valid (mem_q.valid),
    .reg_wr(mem_q.reg_wr),
    .rw    (mem_q.rw),
    .r     (rt_n),
    .hit   (mem_rt)
  );

  dep_match u_wr_rs (
    .valid (wr_q.valid),
    .reg_wr(wr_q.reg_wr),
    .rw    (wr_q.rw),
    .r     (rs_n),
    .hit   (wr_rs)
  );

  dep_match u_wr_rt (
    .valid (wr_q.valid),
    .reg_wr(wr_q.reg_wr),
    .rw    (wr_q.rw),
    .r     (rt_n),
    .hit   (wr_rt)
  );

  // Register file does not bypass, so wait out WR as well.
  assign hazard = id_valid &
    ((id_use_rs & (ex_rs | mem_rs | wr_rs)) |
     (id_use_rt & (ex_rt | mem_rt | wr_rt)));

  assign fwd_a = FWD_IDEX;
  assign fwd_b = FWD_IDEX;

  logic unused_mode;
  assign unused_mode = ^{ex_q.rs, ex_q.rt, ex_q.mem_to_reg,
                         mem_q.mem_to_reg, wr_q.mem_to_reg};
`endif

  logic unused_slot;
  assign unused_slot = ^{mem_q.rs, mem_q.rt, wr_q.rs, wr_q.rt};

  assign ifid_flush  = ex_br_taken;
  assign idex_bubble = ex_br_taken | hazard;
  assign pc_stall    = hazard & ~ex_br_taken;

  always_comb begin
    ex_d = '0;
    if (id_valid && !idex_bubble) begin
      ex_d.valid      = 1'b1;
      ex_d.reg_wr     = id_reg_wr;
      ex_d.rw         = SLOT_RW'(id_rw);
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.rs         = rs_n;
      ex_d.rt         = rt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wr_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wr_q  <= mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (pc_stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (hazard) state_d = STALL;
      STALL:   if (!hazard) state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (ex_br_taken) state_d = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle vector table plus
// reset-mid-stall and stall counter saturation sequences.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_rw;
  logic          id_use_rs, id_use_rt;
  logic          id_reg_wr, id_mem_to_reg;
  logic          ex_br_taken;
  logic          pc_stall, idex_bubble, ifid_flush;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    fsm_state;

  hazard_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_reg_wr    (id_reg_wr),
    .id_rw        (id_rw),
    .id_mem_to_reg(id_mem_to_reg),
    .ex_br_taken  (ex_br_taken),
    .pc_stall     (pc_stall),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt),
    .fsm_state    (fsm_state)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt, wr;
    logic [4:0] rw;
    logic       m2r;
  } ins_t;

  typedef struct {
    ins_t          i;
    logic          br;
    logic          stall, bub, flush;
    logic [1:0]    fa, fb;
    logic [CW-1:0] cnt;
    logic [1:0]    st;
  } vec_t;

  vec_t vt[$];
  int nvec = 0;
  int nbad = 0;

  function automatic ins_t mi(logic [4:0] rs, logic [4:0] rt,
                              logic urs, logic urt, logic wr,
                              logic [4:0] rw, logic m2r);
    ins_t r;
    r.v = 1'b1; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.wr = wr; r.rw = rw; r.m2r = m2r;
    return r;
  endfunction

  ins_t nop, lw2, add324, add267, sub522, add0, add300;

  function automatic void pv(ins_t i, logic br, logic s, logic b,
                             logic f, logic [1:0] fa, logic [1:0] fb,
                             int cnt, hz_state_t st);
    vec_t e;
    e.i = i; e.br = br; e.stall = s; e.bub = b; e.flush = f;
    e.fa = fa; e.fb = fb; e.cnt = CW'(cnt); e.st = st;
    vt.push_back(e);
  endfunction

  task automatic drive(ins_t i, logic br);
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt;
    id_use_rs = i.urs; id_use_rt = i.urt;
    id_reg_wr = i.wr; id_rw = i.rw; id_mem_to_reg = i.m2r;
    ex_br_taken = br;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, vec_t e);
    chk({tag, ".pc_stall"}, pc_stall, e.stall);
    chk({tag, ".idex_bubble"}, idex_bubble, e.bub);
    chk({tag, ".ifid_flush"}, ifid_flush, e.flush);
    chk({tag, ".fwd_a"}, fwd_a, e.fa);
    chk({tag, ".fwd_b"}, fwd_b, e.fb);
    chk({tag, ".stall_cnt"}, stall_cnt, e.cnt);
    chk({tag, ".fsm"}, fsm_state, e.st);
  endtask

  task automatic cyc(ins_t i);
    @(negedge clk);
    drive(i, 1'b0);
    #1;
  endtask

  initial begin
    int c;
    nop    = '{v: 1'b0, default: '0};
    lw2    = mi(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
    add324 = mi(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    add267 = mi(5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
    sub522 = mi(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    add0   = mi(5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
    add300 = mi(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);

`ifdef FORWARD_EN
    pv(lw2,    0, 0, 0, 0, 2'b00, 2'b00, 0, RUN);
    pv(add324, 0, 1, 1, 0, 2'b00, 2'b00, 0, RUN);
    pv(add324, 0, 0, 0, 0, 2'b00, 2'b00, 1, STALL);
    pv(nop,    0, 0, 0, 0, 2'b10, 2'b00, 1, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 1, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 1, RUN);
    pv(add267, 0, 0, 0, 0, 2'b00, 2'b00, 1, RUN);
    pv(sub522, 0, 0, 0, 0, 2'b00, 2'b00, 1, RUN);
    pv(nop,    0, 0, 0, 0, 2'b01, 2'b01, 1, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 1, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 1, RUN);
    c = 1;
`else
    pv(lw2,    0, 0, 0, 0, 2'b00, 2'b00, 0, RUN);
    pv(add324, 0, 1, 1, 0, 2'b00, 2'b00, 0, RUN);
    pv(add324, 0, 1, 1, 0, 2'b00, 2'b00, 1, STALL);
    pv(add324, 0, 1, 1, 0, 2'b00, 2'b00, 2, STALL);
    pv(add324, 0, 0, 0, 0, 2'b00, 2'b00, 3, STALL);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 3, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 3, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 3, RUN);
    pv(add267, 0, 0, 0, 0, 2'b00, 2'b00, 3, RUN);
    pv(sub522, 0, 1, 1, 0, 2'b00, 2'b00, 3, RUN);
    pv(sub522, 0, 1, 1, 0, 2'b00, 2'b00, 4, STALL);
    pv(sub522, 0, 1, 1, 0, 2'b00, 2'b00, 5, STALL);
    pv(sub522, 0, 0, 0, 0, 2'b00, 2'b00, 6, STALL);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 6, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 6, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, 6, RUN);
    c = 6;
`endif
    pv(add0,   0, 0, 0, 0, 2'b00, 2'b00, c, RUN);
    pv(add300, 0, 0, 0, 0, 2'b00, 2'b00, c, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, c, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, c, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, c, RUN);
    pv(lw2,    0, 0, 0, 0, 2'b00, 2'b00, c, RUN);
    pv(add324, 1, 0, 1, 1, 2'b00, 2'b00, c, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, c, FLUSH);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, c, RUN);
    pv(nop,    0, 0, 0, 0, 2'b00, 2'b00, c, RUN);

    rst = 1'b1;
    drive(nop, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.pc_stall", pc_stall, 1'b0);
    chk("reset.idex_bubble", idex_bubble, 1'b0);
    chk("reset.ifid_flush", ifid_flush, 1'b0);
    chk("reset.fwd_a", fwd_a, 2'b00);
    chk("reset.fwd_b", fwd_b, 2'b00);
    chk("reset.stall_cnt", stall_cnt, 0);
    chk("reset.fsm", fsm_state, RUN);

    foreach (vt[k]) begin
      @(negedge clk);
      drive(vt[k].i, vt[k].br);
      #1;
      chk_all($sformatf("vec%0d", k), vt[k]);
    end

    // reset arriving while a load-use stall is active
    cyc(nop);
    cyc(lw2);
    cyc(add324);
    chk("rst_mid.pre_stall", pc_stall, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(add324, 1'b0);
    #1;
    chk("rst_mid.pc_stall", pc_stall, 1'b0);
    chk("rst_mid.idex_bubble", idex_bubble, 1'b0);
    chk("rst_mid.ifid_flush", ifid_flush, 1'b0);
    chk("rst_mid.fwd_a", fwd_a, 2'b00);
    chk("rst_mid.stall_cnt", stall_cnt, 0);
    chk("rst_mid.fsm", fsm_state, RUN);
    cyc(nop);
    cyc(lw2);
    cyc(add324);
    chk("rst_after.pc_stall", pc_stall, 1'b1);
    chk("rst_after.idex_bubble", idex_bubble, 1'b1);
    cyc(add324);
    chk("rst_after.stall_cnt", stall_cnt, 1);
    chk("rst_after.fsm", fsm_state, STALL);
    repeat (4) cyc(nop);

    // eight more load-use pairs push the 3-bit counter past its top
    for (int p = 0; p < 8; p++) begin
      cyc(lw2);
      for (int k = 0; k < 6; k++) begin
        cyc(add324);
        if (!pc_stall) break;
        if (k == 5) chk("sat.stall_bound", 1'b1, 1'b0);
      end
    end
    repeat (4) cyc(nop);
    chk("sat.stall_cnt", stall_cnt, 7);
    chk("sat.pc_stall", pc_stall, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
